// File: rtl/ame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ame_pkg
// Description : Shared widths, types and the saturating add helper for the
//               power-of-two approximate MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package ame_pkg;

    localparam int AME_DATA_W = 8;
    localparam int AME_EXP_W  = 3;

    typedef logic [AME_EXP_W-1:0] ame_exp_t;

    typedef struct packed {
        logic sat;
        logic forced;
        logic bad;
    } ame_flag_t;

    // Adds acc + p and clamps to a signed range of 'width' bits.
    // Bit 64 of the result is the saturation indicator and bits 63:0 hold
    // the clamped sum, sign-extended.
    function automatic logic [64:0] sat_add(
        input logic signed [63:0] acc,
        input logic signed [63:0] p,
        input int                 width
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic        [64:0] res;
        sum = acc + p;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (width - 1));
        if (sum > hi) begin
            res = {1'b1, hi};
        end else if (sum < lo) begin
            res = {1'b1, lo};
        end else begin
            res = {1'b0, sum};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ame_oh2exp.sv
`default_nettype none
// ============================================================================
// Module      : ame_oh2exp
// Description : One-hot operand decoder. Produces the bit index as exponent,
//               a zero flag (no bit or several bits set) and a bad flag
//               (several bits set).
// Revision    : 1.0 - initial release
// ============================================================================
module ame_oh2exp
    import ame_pkg::*;
(
    input  logic [AME_DATA_W-1:0] i_oh,
    output ame_exp_t              o_exp,
    output logic                  o_zero,
    output logic                  o_bad
);

    logic [3:0] w_pop;

    // Population count and index of the set bit (meaningful only when one-hot)
    always_comb begin
        w_pop = '0;
        o_exp = '0;
        for (int i = 0; i < AME_DATA_W; i++) begin
            if (i_oh[i]) begin
                w_pop = w_pop + 4'd1;
                o_exp = AME_EXP_W'(i);
            end
        end
    end

    assign o_zero = (w_pop != 4'd1);
    assign o_bad  = (w_pop > 4'd1);

endmodule
`default_nettype wire

// File: rtl/ame_pow2_mac.sv
`default_nettype none
// ============================================================================
// Module      : ame_pow2_mac
// Description : Three-stage approximate MAC for one-hot power-of-two operands.
//               S1 decodes, S2 forms +/-2^(ea+eb), S3 accumulates a group
//               with saturation and hands one result per group downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module ame_pow2_mac
    import ame_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_last_i,
    input  logic [AME_DATA_W-1:0] a_oh_i,
    input  logic [AME_DATA_W-1:0] b_oh_i,
    input  logic                  neg_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ACC_W-1:0]      out_sum_o,
    output logic [CNT_W-1:0]      out_cnt_o,
    output logic [2:0]            out_flag_o
);

    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_LEN);

    // ---------------- S1 decode ----------------
    ame_exp_t w_ea;
    ame_exp_t w_eb;
    logic     w_za;
    logic     w_zb;
    logic     w_bada;
    logic     w_badb;

    ame_oh2exp u_dec_a (
        .i_oh   (a_oh_i),
        .o_exp  (w_ea),
        .o_zero (w_za),
        .o_bad  (w_bada)
    );

    ame_oh2exp u_dec_b (
        .i_oh   (b_oh_i),
        .o_exp  (w_eb),
        .o_zero (w_zb),
        .o_bad  (w_badb)
    );

    logic     w_adv;
    logic     r_s1_valid;
    ame_exp_t r_s1_ea;
    ame_exp_t r_s1_eb;
    logic     r_s1_zero;
    logic     r_s1_bad;
    logic     r_s1_neg;
    logic     r_s1_last;

    // ---------------- S2 product ----------------
    logic        [3:0]  w_exp_sum;
    logic        [16:0] w_mag;
    logic signed [16:0] w_prod;
    logic               r_s2_valid;
    logic signed [16:0] r_s2_p;
    logic               r_s2_bad;
    logic               r_s2_last;

    // ---------------- S3 accumulate ----------------
    logic signed [ACC_W-1:0] r_acc;
    logic        [CNT_W-1:0] r_cnt;
    logic                    r_sat;
    logic                    r_bad;
    logic        [64:0]      w_sa;
    logic        [ACC_W-1:0] w_acc_next;
    logic        [CNT_W-1:0] w_cnt_next;
    logic                    w_full;
    logic                    w_close;
    ame_flag_t               w_flag_next;
    logic                    w_unused_hi;

    // Any stall downstream freezes every stage, so one enable drives them all
    assign in_ready_o = !out_valid_o | out_ready_i;
    assign w_adv      = in_ready_o;

    // Signed power-of-two product; a zero operand forces the product to 0
    always_comb begin
        w_exp_sum = {1'b0, r_s1_ea} + {1'b0, r_s1_eb};
        w_mag     = 17'(15'd1 << w_exp_sum);
        w_prod    = '0;
        if (!r_s1_zero) begin
            w_prod = r_s1_neg ? -w_mag : w_mag;
        end
    end

    assign w_sa        = sat_add(64'(r_acc), 64'(r_s2_p), ACC_W);
    assign w_acc_next  = w_sa[ACC_W-1:0];
    assign w_unused_hi = ^w_sa[63:ACC_W];
    assign w_cnt_next  = r_cnt + CNT_W'(1);
    assign w_full      = (w_cnt_next == C_MAX_CNT);
    assign w_close     = r_s2_valid & (r_s2_last | w_full);

    // Flags are sticky over the group and include the closing beat's own bits
    always_comb begin
        w_flag_next.sat    = w_sa[64] | r_sat;
        w_flag_next.forced = w_full & !r_s2_last;
        w_flag_next.bad    = r_bad | r_s2_bad;
    end

    // Pipeline registers, group accumulator and output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_ea     <= '0;
            r_s1_eb     <= '0;
            r_s1_zero   <= 1'b0;
            r_s1_bad    <= 1'b0;
            r_s1_neg    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_p      <= '0;
            r_s2_bad    <= 1'b0;
            r_s2_last   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_bad       <= 1'b0;
            out_valid_o <= 1'b0;
            out_sum_o   <= '0;
            out_cnt_o   <= '0;
            out_flag_o  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid_i;
            r_s1_ea    <= w_ea;
            r_s1_eb    <= w_eb;
            r_s1_zero  <= w_za | w_zb;
            r_s1_bad   <= w_bada | w_badb;
            r_s1_neg   <= neg_i;
            r_s1_last  <= in_last_i;

            r_s2_valid <= r_s1_valid;
            r_s2_p     <= w_prod;
            r_s2_bad   <= r_s1_bad;
            r_s2_last  <= r_s1_last;

            if (w_close) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_sat <= 1'b0;
                r_bad <= 1'b0;
            end else if (r_s2_valid) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                r_sat <= w_flag_next.sat;
                r_bad <= w_flag_next.bad;
            end

            // Advancing means any held result was consumed, so valid follows close
            out_valid_o <= w_close;
            if (w_close) begin
                out_sum_o  <= w_acc_next;
                out_cnt_o  <= w_cnt_next;
                out_flag_o <= w_flag_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ame_pow2_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_ame_pow2_mac
// Description : Self-checking bench for ame_pow2_mac: vector table, directed
//               multi-cycle sequences and a randomized run against a
//               group-level arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ame_pow2_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       neg;
    logic       out_ready;
    logic       rdy_hi;
    logic [7:0] a_oh;
    logic [7:0] b_oh;
    logic [1:0] sel;

    logic        rdy0, ov0, rdy1, ov1, rdy2, ov2;
    logic [23:0] sum0;
    logic [6:0]  cnt0;
    logic [2:0]  flag0;
    logic [16:0] sum1;
    logic [6:0]  cnt1;
    logic [2:0]  flag1;
    logic [23:0] sum2;
    logic [2:0]  cnt2;
    logic [2:0]  flag2;

    ame_pow2_mac #(.ACC_W(24), .MAX_LEN(64), .CNT_W(7)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid && sel == 2'd0), .in_ready_o(rdy0),
        .in_last_i(in_last), .a_oh_i(a_oh), .b_oh_i(b_oh), .neg_i(neg),
        .out_valid_o(ov0), .out_ready_i(out_ready), .out_sum_o(sum0), .out_cnt_o(cnt0),
        .out_flag_o(flag0)
    );

    ame_pow2_mac #(.ACC_W(17), .MAX_LEN(64), .CNT_W(7)) u_dut_sat (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid && sel == 2'd1), .in_ready_o(rdy1),
        .in_last_i(in_last), .a_oh_i(a_oh), .b_oh_i(b_oh), .neg_i(neg),
        .out_valid_o(ov1), .out_ready_i(rdy_hi), .out_sum_o(sum1), .out_cnt_o(cnt1),
        .out_flag_o(flag1)
    );

    ame_pow2_mac #(.ACC_W(24), .MAX_LEN(4), .CNT_W(3)) u_dut_len (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid && sel == 2'd2), .in_ready_o(rdy2),
        .in_last_i(in_last), .a_oh_i(a_oh), .b_oh_i(b_oh), .neg_i(neg),
        .out_valid_o(ov2), .out_ready_i(rdy_hi), .out_sum_o(sum2), .out_cnt_o(cnt2),
        .out_flag_o(flag2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // ---------------- group-level reference model (main DUT) ----------------
    typedef struct {
        longint sum;
        int     cnt;
        int     flag;
    } res_t;

    res_t   exp_q[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_sat = 0;
    bit     m_bad = 0;

    // Operand value of a one-hot word is the word itself; anything else is 0
    function automatic longint oh_val(input logic [7:0] v);
        return ($countones(v) == 1) ? longint'(v) : 64'sd0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_acc = 0; m_cnt = 0; m_sat = 0; m_bad = 0;
        end else begin
            if (ov0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("sb_unexpected_output");
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_sum",  longint'($signed(sum0)), e.sum);
                    check("sb_cnt",  longint'(cnt0), longint'(e.cnt));
                    check("sb_flag", longint'(flag0), longint'(e.flag));
                end
            end
            if (sel == 2'd0 && in_valid && rdy0) begin
                longint p;
                longint s;
                res_t   r;
                p = oh_val(a_oh) * oh_val(b_oh);
                if (neg) p = -p;
                s = m_acc + p;
                if (s > 64'sd8388607)  begin s = 64'sd8388607;  m_sat = 1; end
                if (s < -64'sd8388608) begin s = -64'sd8388608; m_sat = 1; end
                m_acc = s;
                m_cnt++;
                if ($countones(a_oh) > 1 || $countones(b_oh) > 1) m_bad = 1;
                if (in_last || m_cnt == 64) begin
                    r.sum  = m_acc;
                    r.cnt  = m_cnt;
                    r.flag = (m_sat ? 4 : 0) + ((!in_last) ? 2 : 0) + (m_bad ? 1 : 0);
                    exp_q.push_back(r);
                    m_acc = 0; m_cnt = 0; m_sat = 0; m_bad = 0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic cur_rdy();
        case (sel)
            2'd0:    return rdy0;
            2'd1:    return rdy1;
            default: return rdy2;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat was accepted
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic n, input logic l);
        bit ok;
        ok = 0;
        a_oh = a; b_oh = b; neg = n; in_last = l; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cur_rdy()) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) timeout_fail("send_accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    longint g_sum;
    int     g_cnt;
    int     g_flag;

    task automatic wait_out(input int s, input int budget);
        bit ok;
        ok = 0;
        g_sum = 0; g_cnt = -1; g_flag = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (s == 0 && ov0) begin
                g_sum = $signed(sum0); g_cnt = int'(cnt0); g_flag = int'(flag0); ok = 1; break;
            end
            if (s == 1 && ov1) begin
                g_sum = $signed(sum1); g_cnt = int'(cnt1); g_flag = int'(flag1); ok = 1; break;
            end
            if (s == 2 && ov2) begin
                g_sum = $signed(sum2); g_cnt = int'(cnt2); g_flag = int'(flag2); ok = 1; break;
            end
        end
        if (!ok) timeout_fail("wait_out");
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       n;
        longint     sum;
        int         flag;
    } vec_t;

    vec_t       tbl[9];
    bit         rand_run;
    logic [7:0] ra, rb;

    function automatic logic [7:0] rand_oh();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'($urandom);
        return 8'(1 << $urandom_range(0, 7));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h04, 8'h08, 1'b0, 32,     0};
        tbl[1] = '{8'h05, 8'h01, 1'b0, 0,      1};
        tbl[2] = '{8'h01, 8'h01, 1'b0, 1,      0};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 0,      0};
        tbl[4] = '{8'h80, 8'h80, 1'b1, -16384, 0};
        tbl[5] = '{8'h10, 8'h20, 1'b1, -512,   0};
        tbl[6] = '{8'h00, 8'h40, 1'b0, 0,      0};
        tbl[7] = '{8'h02, 8'hFF, 1'b1, 0,      1};
        tbl[8] = '{8'h40, 8'h02, 1'b0, 128,    0};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; neg = 1'b0;
        a_oh = '0; b_oh = '0; out_ready = 1'b1; rdy_hi = 1'b1; sel = 2'd0;
        rand_run = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", longint'(ov0),   0);
        check("reset_sum",   longint'(sum0),  0);
        check("reset_cnt",   longint'(cnt0),  0);
        check("reset_flag",  longint'(flag0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", longint'(rdy0), 1);
        @(posedge clk); #1;

        // Latency: beat accepted at T, result visible at T+3
        a_oh = 8'h04; b_oh = 8'h08; neg = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); check("lat_t1_valid", longint'(ov0), 0);
        @(posedge clk); @(negedge clk); check("lat_t2_valid", longint'(ov0), 0);
        @(posedge clk); @(negedge clk);
        check("lat_t3_valid", longint'(ov0), 1);
        check("lat_t3_sum",   longint'($signed(sum0)), 32);
        check("lat_t3_cnt",   longint'(cnt0), 1);
        @(posedge clk); @(negedge clk); check("lat_t4_drop", longint'(ov0), 0);
        @(posedge clk); #1;

        // Single-beat groups from the vector table
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].n, 1'b1);
            wait_out(0, 20);
            check($sformatf("tbl%0d_sum", i),  g_sum, tbl[i].sum);
            check($sformatf("tbl%0d_cnt", i),  longint'(g_cnt), 1);
            check($sformatf("tbl%0d_flag", i), longint'(g_flag), longint'(tbl[i].flag));
        end

        // Three-beat mixed-sign group
        send(8'h01, 8'h01, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b0);
        send(8'h02, 8'h04, 1'b0, 1'b1);
        wait_out(0, 20);
        check("grp3_sum",  g_sum, -16375);
        check("grp3_cnt",  longint'(g_cnt), 3);
        check("grp3_flag", longint'(g_flag), 0);

        // Saturation with ACC_W = 17
        sel = 2'd1;
        for (int i = 0; i < 5; i++) send(8'h80, 8'h80, 1'b0, (i == 4));
        wait_out(1, 20);
        check("sat_sum",  g_sum, 65535);
        check("sat_cnt",  longint'(g_cnt), 5);
        check("sat_flag", longint'(g_flag), 4);

        // Forced close with MAX_LEN = 4, then the remainder group
        sel = 2'd2;
        for (int i = 0; i < 6; i++) send(8'h01, 8'h01, 1'b0, (i == 5));
        wait_out(2, 20);
        check("force1_sum",  g_sum, 4);
        check("force1_cnt",  longint'(g_cnt), 4);
        check("force1_flag", longint'(g_flag), 2);
        wait_out(2, 20);
        check("force2_sum",  g_sum, 2);
        check("force2_cnt",  longint'(g_cnt), 2);
        check("force2_flag", longint'(g_flag), 0);
        sel = 2'd0;

        // Backpressure: hold a result while beats keep arriving
        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 8'h01, 1'b0, 1'b1);
                send(8'h02, 8'h01, 1'b0, 1'b0);
                send(8'h02, 8'h02, 1'b0, 1'b1);
                send(8'h04, 8'h04, 1'b1, 1'b1);
                send(8'h08, 8'h01, 1'b0, 1'b1);
            end
            begin
                bit seen;
                seen = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (ov0) begin seen = 1; break; end
                end
                if (!seen) timeout_fail("stall_wait");
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready", longint'(rdy0), 0);
                    check("stall_valid", longint'(ov0),  1);
                    check("stall_hold",  longint'($signed(sum0)), 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("stall_drain", longint'(exp_q.size()), 0);

        // Reset in the middle of a group
        send(8'h80, 8'h01, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", longint'(ov0),   0);
        check("midrst_sum",   longint'(sum0),  0);
        check("midrst_cnt",   longint'(cnt0),  0);
        check("midrst_flag",  longint'(flag0), 0);
        @(posedge clk); #1;
        send(8'h02, 8'h02, 1'b0, 1'b1);
        wait_out(0, 20);
        check("postrst_sum", g_sum, 4);
        check("postrst_cnt", longint'(g_cnt), 1);

        // Randomized traffic with random backpressure
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    ra = rand_oh();
                    rb = rand_oh();
                    send(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                send(8'h01, 8'h01, 1'b0, 1'b1);
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rand_drain", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
